// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - self-synchronising LFSR sequence checker with lock, error count and period measurement
module lfsr_seq_checker #(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b1100,
    parameter int               LOCK_CNT   = 3,
    parameter int               MISS_LIMIT = 2,
    parameter int               CNT_W      = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] q_in,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] period,
    output logic             period_valid
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int SW = $clog2(MISS_LIMIT + 1);
    localparam logic [MW-1:0] LOCK_V = MW'(LOCK_CNT);
    localparam logic [SW-1:0] MISS_V = SW'(MISS_LIMIT);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pred, pred_n, seed, seed_n, pcnt, pcnt_n;
    logic [MW-1:0]    match, match_n;
    logic [SW-1:0]    miss, miss_n;
    logic             locked_n, err_n, period_valid_n;
    logic [CNT_W-1:0] err_count_n;
    logic [WIDTH-1:0] period_n;

    function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
        nxt = {x[WIDTH-2:0], ^(x & TAPS)};
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= HUNT;
            pred         <= '0;
            seed         <= '0;
            pcnt         <= '0;
            match        <= '0;
            miss         <= '0;
            locked       <= 1'b0;
            err          <= 1'b0;
            err_count    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
        end else begin
            state        <= state_n;
            pred         <= pred_n;
            seed         <= seed_n;
            pcnt         <= pcnt_n;
            match        <= match_n;
            miss         <= miss_n;
            locked       <= locked_n;
            err          <= err_n;
            err_count    <= err_count_n;
            period       <= period_n;
            period_valid <= period_valid_n;
        end
    end

    always_comb begin
        state_n        = state;
        pred_n         = pred;
        seed_n         = seed;
        pcnt_n         = pcnt;
        match_n        = match;
        miss_n         = miss;
        locked_n       = locked;
        err_n          = 1'b0;
        err_count_n    = err_count;
        period_n       = period;
        period_valid_n = period_valid;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (q_in != '0) begin
                        pred_n  = nxt(q_in);
                        match_n = '0;
                        state_n = VERIFY;
                    end
                end
                VERIFY: begin
                    if (q_in == pred) begin
                        pred_n = nxt(pred);
                        if (match == LOCK_V - 1'b1) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            seed_n   = q_in;
                            pcnt_n   = WIDTH'(1);
                            miss_n   = '0;
                            match_n  = LOCK_V;
                        end else begin
                            match_n = match + 1'b1;
                        end
                    end else if (q_in != '0) begin
                        pred_n  = nxt(q_in);
                        match_n = '0;
                    end else begin
                        state_n = HUNT;
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the predictor free-runs and is never reseeded from q_in here.
                    pred_n = nxt(pred);
                    if (q_in == pred) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (err_count != '1)
                            err_count_n = err_count + 1'b1;
                        if (miss == MISS_V - 1'b1) begin
                            state_n  = HUNT;
                            locked_n = 1'b0;
                            pcnt_n   = '0;
                            miss_n   = '0;
                        end else begin
                            miss_n = miss + 1'b1;
                        end
                    end
                    if (state_n == LOCKED) begin
                        if (pred == seed) begin
                            period_n       = pcnt;
                            period_valid_n = 1'b1;
                            pcnt_n         = WIDTH'(1);
                        end else if (pcnt != '1) begin
                            pcnt_n = pcnt + 1'b1;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb/tb_lfsr_seq_checker.sv - randomized self-checking bench for lfsr_seq_checker
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       locked, err, period_valid;
    logic [7:0] err_count;
    logic [3:0] period;

    int passed = 0;
    int total  = 0;
    logic [3:0] g;

    // Reference model state, plain integers
    int m_mode, m_pred, m_match, m_miss, m_seed, m_pcnt;
    int e_locked, e_err, e_cnt, e_period, e_pv;

    lfsr_seq_checker dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .q_in(q_in),
        .locked(locked), .err(err), .err_count(err_count),
        .period(period), .period_valid(period_valid)
    );

    always #5 clk = ~clk;

    function automatic int nx(input int x);
        return ((x << 1) & 15) | (((x >> 3) ^ (x >> 2)) & 1);
    endfunction

    function automatic logic [14:0] dutv();
        return {locked, err, err_count, period, period_valid};
    endfunction

    function automatic logic [14:0] expv();
        return {e_locked[0], e_err[0], e_cnt[7:0], e_period[3:0], e_pv[0]};
    endfunction

    task automatic model(input logic c, input logic v, input int q);
        int old;
        if (c) begin
            m_mode = 0; m_pred = 0; m_match = 0; m_miss = 0; m_seed = 0; m_pcnt = 0;
            e_locked = 0; e_err = 0; e_cnt = 0; e_period = 0; e_pv = 0;
            return;
        end
        e_err = 0;
        if (!v) return;
        if (m_mode == 0) begin
            if (q != 0) begin m_pred = nx(q); m_match = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
            if (q == m_pred) begin
                m_match++;
                m_pred = nx(m_pred);
                if (m_match == 3) begin
                    m_mode = 2; e_locked = 1; m_seed = q; m_pcnt = 1; m_miss = 0;
                end
            end else if (q != 0) begin
                m_pred = nx(q); m_match = 0;
            end else begin
                m_mode = 0; m_match = 0;
            end
        end else begin
            old = m_pred;
            m_pred = nx(m_pred);
            if (q == old) m_miss = 0;
            else begin
                e_err = 1;
                if (e_cnt < 255) e_cnt++;
                m_miss++;
                if (m_miss == 2) begin m_mode = 0; e_locked = 0; m_pcnt = 0; m_miss = 0; end
            end
            if (m_mode == 2) begin
                if (old == m_seed) begin e_period = m_pcnt; e_pv = 1; m_pcnt = 1; end
                else if (m_pcnt < 15) m_pcnt++;
            end
        end
    endtask

    task automatic step(input logic c, input logic v, input logic [3:0] q);
        clr = c; in_valid = v; q_in = q;
        @(posedge clk);
        #1;
        model(c, v, int'(q));
    endtask

    task automatic good();
        step(1'b0, 1'b1, g);
        g = 4'(nx(int'(g)));
    endtask

    task automatic bad();
        logic [3:0] b;
        b = g ^ 4'($urandom_range(1, 15));
        step(1'b0, 1'b1, b);
        g = 4'(nx(int'(g)));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0);
        total++;
        if (dutv() !== 15'd0) $display("FAIL reset: got %h want 0", dutv()); else passed++;
        total++;
        if (dutv() !== expv()) $display("FAIL reset_model: got %h want %h", dutv(), expv()); else passed++;
    endtask

    task automatic test_lock();
        step(1'b1, 1'b0, 4'd0);
        g = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            good();
            total++;
            if (locked !== (i == 3)) $display("FAIL lock_step%0d: locked=%b want %b", i, locked, (i == 3));
            else passed++;
            total++;
            if (err !== 1'b0) $display("FAIL lock_err%0d: err=%b want 0", i, err); else passed++;
        end
    endtask

    task automatic test_period();
        for (int i = 0; i < 40; i++) begin
            good();
            total++;
            if (dutv() !== expv()) $display("FAIL period_cyc%0d: got %h want %h", i, dutv(), expv());
            else passed++;
        end
        total++;
        if (period !== 4'd15 || period_valid !== 1'b1 || err_count !== 8'd0)
            $display("FAIL period_final: period=%0d pv=%b cnt=%0d want 15 1 0", period, period_valid, err_count);
        else passed++;
    endtask

    task automatic test_single_error();
        int c0;
        for (int k = 0; k < 2; k++) begin
            c0 = e_cnt;
            while (g == 4'hf) good();
            step(1'b0, 1'b1, 4'hf);
            g = 4'(nx(int'(g)));
            total++;
            if (err !== 1'b1 || locked !== 1'b1 || int'(err_count) !== c0 + 1)
                $display("FAIL single_err%0d: err=%b locked=%b cnt=%0d want 1 1 %0d", k, err, locked, err_count, c0 + 1);
            else passed++;
            good();
            total++;
            if (err !== 1'b0 || locked !== 1'b1)
                $display("FAIL single_recover%0d: err=%b locked=%b want 0 1", k, err, locked);
            else passed++;
        end
    endtask

    task automatic test_loss_of_lock();
        int c0;
        c0 = e_cnt;
        bad();
        bad();
        total++;
        if (locked !== 1'b0 || int'(err_count) !== c0 + 2)
            $display("FAIL loss: locked=%b cnt=%0d want 0 %0d", locked, err_count, c0 + 2);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            good();
            total++;
            if (locked !== (i == 3)) $display("FAIL relock_step%0d: locked=%b want %b", i, locked, (i == 3));
            else passed++;
        end
        step(1'b1, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'd0);
        total++;
        if (locked !== 1'b0 || err !== 1'b0 || err_count !== 8'd0)
            $display("FAIL zero_hunt: locked=%b err=%b cnt=%0d want 0 0 0", locked, err, err_count);
        else passed++;
    endtask

    task automatic test_gaps_and_clr();
        int nv;
        step(1'b1, 1'b0, 4'd0);
        g = 4'($urandom_range(1, 15));
        nv = 0;
        while (nv < 60) begin
            if ($urandom_range(0, 1) == 1) begin good(); nv++; end
            else step(1'b0, 1'b0, 4'($urandom));
            total++;
            if (dutv() !== expv()) $display("FAIL gaps_cyc: got %h want %h", dutv(), expv());
            else passed++;
        end
        total++;
        if (period !== 4'd15 || period_valid !== 1'b1 || err_count !== 8'd0 || locked !== 1'b1)
            $display("FAIL gaps_final: period=%0d pv=%b cnt=%0d locked=%b", period, period_valid, err_count, locked);
        else passed++;
        step(1'b1, 1'b1, g);
        total++;
        if (dutv() !== 15'd0) $display("FAIL clr_midlock: got %h want 0", dutv()); else passed++;
    endtask

    task automatic test_random();
        int r;
        step(1'b1, 1'b0, 4'd0);
        g = 4'($urandom_range(1, 15));
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 4) step(1'b0, 1'b0, 4'($urandom));
            else if (r < 6) bad();
            else if (r == 6) step(1'b1, 1'b0, 4'd0);
            else good();
            total++;
            if (dutv() !== expv()) $display("FAIL random_cyc%0d: got %h want %h", i, dutv(), expv());
            else passed++;
        end
    endtask

    initial begin
        model(1'b1, 1'b0, 0);
        #2;
        test_reset();
        test_lock();
        test_period();
        test_single_error();
        test_loss_of_lock();
        test_gaps_and_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
